sram_responder: RTL and testbench

- On-chip responder for the time-multiplexed external-SRAM bus driven by the two-port SRAM arbiter, clocked on clk2x.
- Decodes ram_address / ram_rd_n / ram_wr_n / dataenable and serves single-cycle word reads and byte-enabled writes from a local array.
- Clears its array after reset and flags protocol or range violations.
- Used as the SRAM stand-in for on-chip builds and as the bus checker in simulation.

---
 rtl/sram_pkg.sv | 17 +
 rtl/sram_resp_mem.sv | 29 ++
 rtl/sram_responder.sv | 105 ++++++++++
 tb/tb_sram_responder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared widths, responder state encoding and the address-window decode helper
// for the external-SRAM bus responder.
package sram_pkg;
   localparam int WORD_W = 32;
   localparam int BE_W   = 4;

   typedef enum logic {ST_INIT, ST_RUN} resp_state_e;

   // True when addr falls in the 4*2**aw byte window starting at base.
   function automatic logic addr_in_range(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input int unsigned aw);
      logic [31:0] mask;
      mask = 32'hFFFF_FFFF << (aw + 2);
      return ((addr ^ base) & mask) == 32'h0;
   endfunction
endpackage

// File: rtl/sram_resp_mem.sv
// DEPTH x 32 word array: asynchronous read port, one synchronous
// byte-enabled write port.
module sram_resp_mem
   import sram_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk2x,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [BE_W-1:0]       wbe,
   input  logic [WORD_W-1:0]     wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [WORD_W-1:0]     rdata
);
   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk2x) begin
      if (we) begin
         for (int i = 0; i < BE_W; i++) begin
            if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/sram_responder.sv
// Zero-wait-state SRAM stand-in and bus checker on clk2x; clears its array after
// reset. Define SRAM_RESP_STATS_EN to build the saturating rd/wr access counters.
module sram_responder
   import sram_pkg::*;
#(
   parameter int          ADDR_WIDTH = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic              clk2x,
   input  logic              rst,
   input  logic [31:0]       ram_address,
   input  logic [WORD_W-1:0] ram_data_w,
   output logic [WORD_W-1:0] ram_data_r,
   input  logic              ram_wr_n,
   input  logic              ram_rd_n,
   input  logic [BE_W-1:0]   dataenable,
   output logic              init_done,
   output logic              proto_err,
   output logic              range_err,
   output logic [31:0]       err_addr,
   output logic [31:0]       rd_count,
   output logic [31:0]       wr_count
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

   resp_state_e           state;
   logic [ADDR_WIDTH-1:0] init_ptr;
   logic [ADDR_WIDTH-1:0] idx;
   logic                  in_range, run;
   logic                  rd_ok, wr_ok, both_low, bad_range;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [BE_W-1:0]       mem_wbe;
   logic [WORD_W-1:0]     mem_wdata, mem_rdata;

   assign idx       = ram_address[ADDR_WIDTH+1:2];
   assign in_range  = addr_in_range(ram_address, BASE_ADDR, ADDR_WIDTH);
   assign run       = (state == ST_RUN);
   assign rd_ok     = run && !ram_rd_n && ram_wr_n && in_range;
   assign wr_ok     = run && !ram_wr_n && ram_rd_n && in_range;
   assign both_low  = run && !ram_rd_n && !ram_wr_n;
   assign bad_range = run && (!ram_rd_n || !ram_wr_n) && !in_range;

   // The clear sequence owns the write port until the array is zeroed.
   assign mem_we    = !run || wr_ok;
   assign mem_waddr = run ? idx        : init_ptr;
   assign mem_wbe   = run ? dataenable : {BE_W{1'b1}};
   assign mem_wdata = run ? ram_data_w : '0;

   sram_resp_mem #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
      .clk2x (clk2x),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wbe   (mem_wbe),
      .wdata (mem_wdata),
      .raddr (idx),
      .rdata (mem_rdata)
   );

   assign ram_data_r = rd_ok ? mem_rdata : '0;

   always_ff @(posedge clk2x) begin
      if (rst) begin
         state     <= ST_INIT;
         init_ptr  <= '0;
         init_done <= 1'b0;
         proto_err <= 1'b0;
         range_err <= 1'b0;
         err_addr  <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               init_ptr <= init_ptr + 1'b1;
               if (init_ptr == LAST_IDX) begin
                  state     <= ST_RUN;
                  init_done <= 1'b1;
               end
            end
            ST_RUN: begin
               if (both_low)  proto_err <= 1'b1;
               if (bad_range) range_err <= 1'b1;
               // Only the first offending address is kept.
               if ((both_low || bad_range) && !(proto_err || range_err))
                  err_addr <= ram_address;
            end
         endcase
      end
   end

`ifdef SRAM_RESP_STATS_EN
   always_ff @(posedge clk2x) begin
      if (rst) begin
         rd_count <= '0;
         wr_count <= '0;
      end else begin
         if (rd_ok && rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
         if (wr_ok && wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
      end
   end
`else
   assign rd_count = '0;
   assign wr_count = '0;
`endif
endmodule

// File: tb/tb_sram_responder.sv
// Randomized scoreboard bench for sram_responder (ADDR_WIDTH=4) against a
// word-array reference model; directed reset/init, byte-enable and error cases.
module tb_sram_responder;
   localparam int AW    = 4;
   localparam int DEPTH = 2**AW;
`ifdef SRAM_RESP_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk2x = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ram_address = '0;
   logic [31:0] ram_data_w = '0;
   logic [31:0] ram_data_r;
   logic        ram_wr_n = 1'b1;
   logic        ram_rd_n = 1'b1;
   logic [3:0]  dataenable = '0;
   logic        init_done, proto_err, range_err;
   logic [31:0] err_addr, rd_count, wr_count;

   sram_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0)) dut (
      .clk2x(clk2x), .rst(rst), .ram_address(ram_address),
      .ram_data_w(ram_data_w), .ram_data_r(ram_data_r),
      .ram_wr_n(ram_wr_n), .ram_rd_n(ram_rd_n), .dataenable(dataenable),
      .init_done(init_done), .proto_err(proto_err), .range_err(range_err),
      .err_addr(err_addr), .rd_count(rd_count), .wr_count(wr_count)
   );

   always #5 clk2x = ~clk2x;

   typedef struct {
      logic [31:0] rdata;
      logic        proto;
      logic        rng;
      logic [31:0] eaddr;
      logic [31:0] rdc;
      logic [31:0] wrc;
   } exp_t;

   exp_t        sb[$];
   logic        drv_vld = 1'b0;
   int          vectors = 0;
   int          errors = 0;

   // Reference model state
   logic [31:0] ref_mem [DEPTH];
   logic        m_proto, m_rng, m_has_err;
   logic [31:0] m_eaddr, m_rdc, m_wrc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      m_proto = 0; m_rng = 0; m_has_err = 0;
      m_eaddr = '0; m_rdc = '0; m_wrc = '0;
   endtask

   // One bus cycle: drive, predict what the DUT shows during it, then advance the model.
   task automatic op(input logic rd_n, input logic wr_n, input logic [31:0] addr,
                     input logic [31:0] data, input logic [3:0] be);
      exp_t e;
      bit   inr, is_rd, is_wr, perr, rerr;
      int   w;
      ram_rd_n = rd_n; ram_wr_n = wr_n; ram_address = addr;
      ram_data_w = data; dataenable = be;
      inr   = (addr / (4 * DEPTH)) == 0;
      w     = int'((addr / 4) % DEPTH);
      is_rd = !rd_n && wr_n && inr;
      is_wr = !wr_n && rd_n && inr;
      perr  = !rd_n && !wr_n;
      rerr  = (!rd_n || !wr_n) && !inr;
      e.rdata = is_rd ? ref_mem[w] : 32'h0;
      e.proto = m_proto; e.rng = m_rng; e.eaddr = m_eaddr;
      e.rdc = STATS ? m_rdc : 32'h0;
      e.wrc = STATS ? m_wrc : 32'h0;
      sb.push_back(e);
      drv_vld = 1'b1;
      if (is_wr)
         for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[w][8*b +: 8] = data[8*b +: 8];
      if (perr) m_proto = 1;
      if (rerr) m_rng = 1;
      if ((perr || rerr) && !m_has_err) begin m_eaddr = addr; m_has_err = 1; end
      if (is_rd && m_rdc != 32'hFFFF_FFFF) m_rdc++;
      if (is_wr && m_wrc != 32'hFFFF_FFFF) m_wrc++;
      @(posedge clk2x); #1;
   endtask

   task automatic idle_bus();
      ram_rd_n = 1; ram_wr_n = 1; ram_address = '0; ram_data_w = '0; dataenable = '0;
   endtask

   // Reset then walk the clear sequence; with noisy set, poke the bus during INIT.
   task automatic do_reset(input bit noisy);
      drv_vld = 1'b0;
      idle_bus();
      rst = 1'b1;
      @(posedge clk2x); #1;
      rst = 1'b0;
      model_reset();
      for (int k = 0; k < DEPTH; k++) begin
         idle_bus();
         if (noisy && k == 5)  begin ram_rd_n = 0; ram_address = 32'h0; end
         if (noisy && k == 10) begin ram_wr_n = 0; ram_address = 32'h8; ram_data_w = '1; dataenable = 4'hF; end
         if (noisy && k == 12) begin ram_rd_n = 0; ram_wr_n = 0; ram_address = 32'h4; end
         if (noisy && k == 13) begin ram_wr_n = 0; ram_address = 32'h80; dataenable = 4'hF; end
         @(negedge clk2x);
         check($sformatf("init_done_c%0d", k), 32'(init_done), 32'h0);
         check("init_rdata", ram_data_r, 32'h0);
         if (k == 0) begin
            check("rst_proto", 32'(proto_err), 32'h0);
            check("rst_range", 32'(range_err), 32'h0);
            check("rst_eaddr", err_addr, 32'h0);
            check("rst_rdc", rd_count, 32'h0);
            check("rst_wrc", wr_count, 32'h0);
         end
         @(posedge clk2x); #1;
      end
      idle_bus();
      @(negedge clk2x);
      check("init_done_final", 32'(init_done), 32'h1);
      @(posedge clk2x); #1;
      for (int i = 0; i < DEPTH; i++) op(0, 1, 32'(i * 4), '0, 4'h0);
   endtask

   // Monitor: compares every driven cycle against the scoreboard.
   always @(negedge clk2x) begin
      if (drv_vld) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 32'h1, 32'h0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rdata", ram_data_r, e.rdata);
            check("proto_err", 32'(proto_err), 32'(e.proto));
            check("range_err", 32'(range_err), 32'(e.rng));
            check("err_addr", err_addr, e.eaddr);
            check("rd_count", rd_count, e.rdc);
            check("wr_count", wr_count, e.wrc);
            check("init_done_run", 32'(init_done), 32'h1);
         end
      end
   end

   initial begin
      logic [31:0] a;
      int          r;
      model_reset();
      @(posedge clk2x); #1;
      // Reset interrupted mid-INIT at cycle 5, then a full clear with bus noise.
      rst = 1'b1; @(posedge clk2x); #1; rst = 1'b0;
      repeat (5) begin @(posedge clk2x); #1; end
      do_reset(1'b1);

      op(1, 0, 32'h8, 32'hDEADBEEF, 4'hF);
      op(0, 1, 32'h8, '0, 4'h0);
      op(1, 0, 32'h8, 32'h11223344, 4'b0101);
      op(0, 1, 32'h8, '0, 4'hF);
      op(1, 0, 32'hC, 32'h55AA55AA, 4'h0);
      op(0, 1, 32'hC, '0, 4'h0);
      op(0, 0, 32'h4, 32'hFFFFFFFF, 4'hF);
      op(1, 0, 32'h40, 32'hCAFEF00D, 4'hF);
      op(0, 1, 32'h40, '0, 4'h0);
      op(0, 1, 32'h0, '0, 4'h0);
      op(1, 1, 32'h8, '0, 4'h0);

      // Random traffic, mostly in range, all strobe combinations.
      for (int n = 0; n < 300; n++) begin
         r = int'($urandom_range(0, 9));
         if ($urandom_range(0, 15) == 0) a = $urandom | 32'h40;
         else a = {26'h0, 4'($urandom), 2'($urandom)};
         if (n < 150 && r == 7) r = 8;
         case (r)
            0, 1, 2, 3: op(0, 1, a, $urandom, 4'($urandom));
            4, 5, 6:    op(1, 0, a, $urandom, 4'($urandom));
            7:          op(0, 0, a, $urandom, 4'($urandom));
            default:    op(1, 1, a, $urandom, 4'($urandom));
         endcase
      end

      // Reset during RUN: data, flags and counters all return to zero.
      op(1, 0, 32'h10, 32'h01020304, 4'hF);
      do_reset(1'b0);
      model_reset();
      op(1, 0, 32'h14, 32'hA5A5A5A5, 4'hF);
      op(0, 1, 32'h14, '0, 4'h0);
      op(1, 0, 32'h18, 32'h5A5A5A5A, 4'h3);
      op(0, 1, 32'h18, '0, 4'h0);
      op(0, 1, 32'h10, '0, 4'h0);
      op(1, 1, 32'h0, '0, 4'h0);
      drv_vld = 1'b0;
      idle_bus();
      @(posedge clk2x); #1;
      check("sb_drained", 32'(sb.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
